// File: rtl/hex_tx_pkg.sv
// Shared types, constants and sizing helpers for the hex word transmitter.
package hex_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitIdle,
    StStrobe,
    StWaitDone
  } state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Characters emitted per word: hex digits, optional separator, optional CR/LF.
  function automatic int unsigned nchar(int unsigned data_w, int unsigned sep_en,
                                        int unsigned crlf);
    return (data_w + 3) / 4 + sep_en + 2 * crlf;
  endfunction

  function automatic int unsigned nchar_idx_w(int unsigned data_w, int unsigned sep_en,
                                              int unsigned crlf);
    int unsigned n;
    n = nchar(data_w, sep_en, crlf);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_word_tx_if.sv
// Word input and uart_tx byte handshake of the hex word transmitter.
interface hex_word_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_busy;

  modport slave (
    input  in_valid, in_data, tx_busy,
    output in_ready, tx_data, tx_en
  );

  modport master (
    output in_valid, in_data, tx_busy,
    input  in_ready, tx_data, tx_en
  );
endinterface

// File: rtl/hex_nibble_ascii.sv
// Maps one 4-bit nibble to its ASCII hex digit.
module hex_nibble_ascii #(
  parameter bit LOWERCASE = 1'b0
) (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);
  logic [7:0] alpha_base;

  // Base chosen so that base + 10 lands on 'a' or 'A'.
  assign alpha_base = LOWERCASE ? 8'h57 : 8'h37;
  assign ascii_o    = ((nibble_i < 4'd10) ? 8'h30 : alpha_base) + {4'h0, nibble_i};
endmodule

// File: rtl/hex_word_tx.sv
// Hex-dump transmitter: prints a word MSB nibble first through a uart_tx handshake.
// Optional CR/LF line ending after each word when HEX_WORD_TX_CRLF_EN is defined.
module hex_word_tx
  import hex_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LOWERCASE = 1'b0,
  parameter bit          SEP_EN    = 1'b1,
  parameter logic [7:0]  SEP_CHAR  = 8'h20
) (
  input  logic         clk,
  input  logic         resetn,
  hex_word_tx_if.slave bus,
  output logic         busy
);
`ifdef HEX_WORD_TX_CRLF_EN
  localparam bit Crlf = 1'b1;
`else
  localparam bit Crlf = 1'b0;
`endif
  localparam int unsigned Nibbles = (DATA_W + 3) / 4;
  localparam int unsigned WordW   = 4 * Nibbles;
  localparam int unsigned NChar   = nchar(DATA_W, 32'(SEP_EN), 32'(Crlf));
  localparam int unsigned IdxW    = nchar_idx_w(DATA_W, 32'(SEP_EN), 32'(Crlf));

  typedef logic [IdxW-1:0] idx_t;

  state_e           state_q, state_d;
  idx_t             idx_q, idx_d;
  logic [WordW-1:0] word_q, word_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_en_q, tx_en_d;
  logic [3:0]       nib_sel;
  logic [7:0]       nib_ascii;
  logic [7:0]       char_next;
  logic             last_char;

  assign last_char = (idx_q == idx_t'(NChar - 1));

  // idx_d is the index of the character about to be strobed, so the byte can be registered.
  always_comb begin
    idx_d = idx_q;
    if (state_q == StWaitDone && !bus.tx_busy) begin
      idx_d = last_char ? '0 : idx_q + idx_t'(1);
    end
  end

  always_comb begin
    nib_sel = '0;
    for (int unsigned i = 0; i < Nibbles; i++) begin
      if (idx_d == idx_t'(i)) nib_sel = word_q[WordW - 4 - 4 * i +: 4];
    end
  end

  hex_nibble_ascii #(
    .LOWERCASE(LOWERCASE)
  ) u_nibble_ascii (
    .nibble_i(nib_sel),
    .ascii_o (nib_ascii)
  );

  always_comb begin
    char_next = nib_ascii;
    if (SEP_EN && idx_d == idx_t'(Nibbles)) char_next = SEP_CHAR;
`ifdef HEX_WORD_TX_CRLF_EN
    if (idx_d == idx_t'(NChar - 2)) char_next = ASCII_CR;
    if (idx_d == idx_t'(NChar - 1)) char_next = ASCII_LF;
`endif
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d = StWaitIdle;
          word_d  = WordW'(bus.in_data);
        end
      end
      // Never strobe while another master still owns the uart.
      StWaitIdle: begin
        if (!bus.tx_busy) begin
          state_d   = StStrobe;
          tx_en_d   = 1'b1;
          tx_data_d = char_next;
        end
      end
      StStrobe: begin
        if (bus.tx_busy) state_d = StWaitDone;
        else             tx_en_d = 1'b1;
      end
      StWaitDone: begin
        if (!bus.tx_busy) begin
          if (last_char) begin
            state_d   = StIdle;
            tx_data_d = '0;
          end else begin
            state_d   = StStrobe;
            tx_en_d   = 1'b1;
            tx_data_d = char_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      word_q    <= '0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      word_q    <= word_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
    end
  end

  assign bus.in_ready = (state_q == StIdle);
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_hex_word_tx.sv
// Bench for hex_word_tx: four configurations driven against a uart_tx model and a
// string-level reference of the expected character stream.
module tb_hex_word_tx;

`ifdef HEX_WORD_TX_CRLF_EN
  localparam bit Crlf = 1'b1;
`else
  localparam bit Crlf = 1'b0;
`endif
  localparam int DW [4] = '{16, 10, 8, 4};
  localparam bit LC [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit SE [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam int Budget = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [3:0]  v_in;
  logic [15:0] d_in [4];
  logic        ext_busy;
  int unsigned blen;

  logic [3:0]  en_a, ready_a, busy_a;
  logic [7:0]  data_a [4];
  logic [3:0]  ubusy = '0;
  logic [3:0]  en_prev = '0;
  int unsigned ucnt [4] = '{default: 0};
  int unsigned rise_cnt [4] = '{default: 0};
  logic [7:0]  rxq [4][$];
  logic [7:0]  exp_q [$];

  int checks = 0;
  int failures = 0;

  hex_word_tx_if #(.DATA_W(16)) if16 ();
  hex_word_tx_if #(.DATA_W(10)) if10 ();
  hex_word_tx_if #(.DATA_W(8))  if8 ();
  hex_word_tx_if #(.DATA_W(4))  if4 ();

  hex_word_tx #(.DATA_W(16), .LOWERCASE(1'b0), .SEP_EN(1'b1), .SEP_CHAR(8'h20)) dut16 (
    .clk(clk), .resetn(resetn), .bus(if16), .busy(busy_a[0]));
  hex_word_tx #(.DATA_W(10), .LOWERCASE(1'b1), .SEP_EN(1'b0), .SEP_CHAR(8'h20)) dut10 (
    .clk(clk), .resetn(resetn), .bus(if10), .busy(busy_a[1]));
  hex_word_tx #(.DATA_W(8), .LOWERCASE(1'b0), .SEP_EN(1'b1), .SEP_CHAR(8'h20)) dut8 (
    .clk(clk), .resetn(resetn), .bus(if8), .busy(busy_a[2]));
  hex_word_tx #(.DATA_W(4), .LOWERCASE(1'b0), .SEP_EN(1'b0), .SEP_CHAR(8'h20)) dut4 (
    .clk(clk), .resetn(resetn), .bus(if4), .busy(busy_a[3]));

  assign if16.in_valid = v_in[0];
  assign if10.in_valid = v_in[1];
  assign if8.in_valid  = v_in[2];
  assign if4.in_valid  = v_in[3];
  assign if16.in_data  = d_in[0];
  assign if10.in_data  = d_in[1][9:0];
  assign if8.in_data   = d_in[2][7:0];
  assign if4.in_data   = d_in[3][3:0];
  assign if16.tx_busy  = ubusy[0] | ext_busy;
  assign if10.tx_busy  = ubusy[1] | ext_busy;
  assign if8.tx_busy   = ubusy[2] | ext_busy;
  assign if4.tx_busy   = ubusy[3] | ext_busy;
  assign en_a    = {if4.tx_en, if8.tx_en, if10.tx_en, if16.tx_en};
  assign ready_a = {if4.in_ready, if8.in_ready, if10.in_ready, if16.in_ready};
  assign data_a[0] = if16.tx_data;
  assign data_a[1] = if10.tx_data;
  assign data_a[2] = if8.tx_data;
  assign data_a[3] = if4.tx_data;

  // uart_tx model: latches a byte on tx_en while idle, then stays busy for blen cycles.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      en_prev[i] <= en_a[i];
      if (en_a[i] && !en_prev[i]) rise_cnt[i] <= rise_cnt[i] + 1;
      if (ucnt[i] != 0) begin
        ucnt[i] <= ucnt[i] - 1;
        if (ucnt[i] == 1) ubusy[i] <= 1'b0;
      end else if (en_a[i] && !ext_busy) begin
        ubusy[i] <= 1'b1;
        ucnt[i]  <= blen;
        rxq[i].push_back(data_a[i]);
      end
    end
  end

  function automatic void model_word(input int id, input logic [63:0] w);
    string hx;
    int    nib;
    nib = (DW[id] + 3) / 4;
    if (LC[id]) hx = "0123456789abcdef";
    else        hx = "0123456789ABCDEF";
    w = w & ((64'd1 << DW[id]) - 64'd1);
    for (int k = nib - 1; k >= 0; k--) exp_q.push_back(hx[int'((w >> (4 * k)) & 64'hF)]);
    if (SE[id]) exp_q.push_back(8'h20);
    if (Crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic string rx_str(input int id, input int from);
    string s;
    s = "";
    for (int k = from; k < rxq[id].size(); k++) s = {s, $sformatf("%02h ", rxq[id][k])};
    return s;
  endfunction

  function automatic string exp_str();
    string s;
    s = "";
    foreach (exp_q[k]) s = {s, $sformatf("%02h ", exp_q[k])};
    return s;
  endfunction

  task automatic offer(input int id, input logic [63:0] w, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    d_in[id] = w[15:0];
    v_in[id] = 1'b1;
    while (!ready_a[id] && n < Budget) begin
      @(negedge clk);
      n++;
    end
    ok = ready_a[id];
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int id, output bit ok);
    int n;
    n = 0;
    while (busy_a[id] && n < Budget) begin
      @(negedge clk);
      n++;
    end
    ok = !busy_a[id];
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    v_in     = '0;
    ext_busy = 1'b0;
    blen     = 10;
    for (int i = 0; i < 4; i++) d_in[i] = '0;
    #3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ready_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || en_a[i] !== 1'b0 || data_a[i] !== 8'h00) begin
        failures++;
        $display("FAIL reset_values dut%0d got ready=%b busy=%b en=%b data=%h want 1 0 0 00",
                 i, ready_a[i], busy_a[i], en_a[i], data_a[i]);
      end
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic16();
    bit ok, ok2;
    int base, rbase;
    blen  = 10;
    base  = rxq[0].size();
    rbase = int'(rise_cnt[0]);
    exp_q.delete();
    model_word(0, 64'hA5C3);
    offer(0, 64'hA5C3, ok);
    v_in[0] = 1'b0;
    d_in[0] = 16'h5A5A;  // must not affect the word in flight
    checks++;
    if (!ok || en_a[0] !== 1'b0 || busy_a[0] !== 1'b1 || ready_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL accept_state got ok=%b en=%b busy=%b ready=%b want 1 0 1 0",
               ok, en_a[0], busy_a[0], ready_a[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (en_a[0] !== 1'b1 || data_a[0] !== 8'h41) begin
      failures++;
      $display("FAIL first_char_latency got en=%b data=%h want en=1 data=41", en_a[0], data_a[0]);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (en_a[0] !== 1'b0 || data_a[0] !== 8'h41) begin
      failures++;
      $display("FAIL held_data got en=%b data=%h want en=0 data=41", en_a[0], data_a[0]);
    end
    wait_done(0, ok2);
    checks++;
    if (!ok2 || rx_str(0, base) != exp_str()) begin
      failures++;
      $display("FAIL basic_seq got '%s' want '%s' done=%b", rx_str(0, base), exp_str(), ok2);
    end
    checks++;
    if (int'(rise_cnt[0]) - rbase != exp_q.size()) begin
      failures++;
      $display("FAIL basic_tx_en_rises got %0d want %0d", int'(rise_cnt[0]) - rbase, exp_q.size());
    end
    checks++;
    if (ubusy[0] !== 1'b0 || ready_a[0] !== 1'b1) begin
      failures++;
      $display("FAIL busy_fall got uart_busy=%b ready=%b want 0 1", ubusy[0], ready_a[0]);
    end
  endtask

  task automatic test_directed();
    int          ids [3] = '{1, 2, 3};
    logic [15:0] words [3] = '{16'h03FF, 16'h000D, 16'h000B};
    bit ok, ok2;
    int base, rbase;
    for (int t = 0; t < 3; t++) begin
      blen  = 4 + t;
      base  = rxq[ids[t]].size();
      rbase = int'(rise_cnt[ids[t]]);
      exp_q.delete();
      model_word(ids[t], 64'(words[t]));
      offer(ids[t], 64'(words[t]), ok);
      v_in[ids[t]] = 1'b0;
      wait_done(ids[t], ok2);
      checks++;
      if (!ok || !ok2 || rx_str(ids[t], base) != exp_str()) begin
        failures++;
        $display("FAIL directed_seq dut%0d word=%h got '%s' want '%s'",
                 ids[t], words[t], rx_str(ids[t], base), exp_str());
      end
      checks++;
      if (int'(rise_cnt[ids[t]]) - rbase != exp_q.size()) begin
        failures++;
        $display("FAIL directed_rises dut%0d got %0d want %0d",
                 ids[t], int'(rise_cnt[ids[t]]) - rbase, exp_q.size());
      end
    end
  endtask

  task automatic test_ext_busy();
    bit ok, ok2;
    int base, viol;
    blen = 3;
    base = rxq[2].size();
    exp_q.delete();
    model_word(2, 64'h7E);
    @(negedge clk);
    ext_busy = 1'b1;
    repeat (50) @(negedge clk);
    offer(2, 64'h7E, ok);
    v_in[2] = 1'b0;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if (en_a[2] !== 1'b0 || busy_a[2] !== 1'b1) viol++;
    end
    checks++;
    if (!ok || viol != 0) begin
      failures++;
      $display("FAIL ext_busy_hold got violations=%0d accepted=%b want 0 1", viol, ok);
    end
    ext_busy = 1'b0;
    wait_done(2, ok2);
    checks++;
    if (!ok2 || rx_str(2, base) != exp_str()) begin
      failures++;
      $display("FAIL ext_busy_seq got '%s' want '%s'", rx_str(2, base), exp_str());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    int base, n;
    blen = 6;
    base = rxq[0].size();
    offer(0, 64'h1234, ok);
    v_in[0] = 1'b0;
    n = 0;
    while (!(en_a[0] && !ubusy[0] && rxq[0].size() == base + 1) && n < Budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!ok || n >= Budget) begin
      failures++;
      $display("FAIL reach_second_char got waited=%0d want < %0d", n, Budget);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (en_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || ready_a[0] !== 1'b1 || data_a[0] !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid got en=%b busy=%b ready=%b data=%h want 0 0 1 00",
               en_a[0], busy_a[0], ready_a[0], data_a[0]);
    end
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    while (ubusy[0] && n < Budget) begin
      @(negedge clk);
      n++;
    end
    base = rxq[0].size();
    exp_q.delete();
    model_word(0, 64'h00FF);
    offer(0, 64'h00FF, ok);
    v_in[0] = 1'b0;
    wait_done(0, ok2);
    checks++;
    if (!ok || !ok2 || rx_str(0, base) != exp_str()) begin
      failures++;
      $display("FAIL after_reset_seq got '%s' want '%s'", rx_str(0, base), exp_str());
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2;
    int base, rbase, n, viol;
    blen  = $urandom_range(2, 8);
    base  = rxq[2].size();
    rbase = int'(rise_cnt[2]);
    exp_q.delete();
    model_word(2, 64'h12);
    model_word(2, 64'h34);
    offer(2, 64'h12, ok);
    d_in[2] = 16'h0034;  // valid stays high
    viol = 0;
    n    = 0;
    while (busy_a[2] && n < Budget) begin
      if (ready_a[2]) viol++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_a[2] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_rise got ready=%b want 1", ready_a[2]);
    end
    @(negedge clk);
    checks++;
    if (busy_a[2] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_gap got busy=%b want 1", busy_a[2]);
    end
    v_in[2] = 1'b0;
    d_in[2] = 16'h00EE;
    n = 0;
    while (busy_a[2] && n < Budget) begin
      if (ready_a[2]) viol++;
      @(negedge clk);
      n++;
    end
    ok2 = !busy_a[2];
    checks++;
    if (!ok || !ok2 || viol != 0) begin
      failures++;
      $display("FAIL b2b_ready_low got violations=%0d done=%b want 0 1", viol, ok2);
    end
    checks++;
    if (rx_str(2, base) != exp_str()) begin
      failures++;
      $display("FAIL b2b_seq got '%s' want '%s'", rx_str(2, base), exp_str());
    end
    checks++;
    if (int'(rise_cnt[2]) - rbase != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_rises got %0d want %0d", int'(rise_cnt[2]) - rbase, exp_q.size());
    end
  endtask

  task automatic test_random();
    bit ok, ok2;
    int id, base, rbase;
    logic [63:0] w;
    for (int it = 0; it < 8; it++) begin
      id    = $urandom_range(0, 3);
      w     = {$urandom(), $urandom()};
      blen  = $urandom_range(1, 12);
      base  = rxq[id].size();
      rbase = int'(rise_cnt[id]);
      exp_q.delete();
      model_word(id, w);
      offer(id, w, ok);
      v_in[id] = 1'b0;
      d_in[id] = 16'($urandom());
      wait_done(id, ok2);
      checks++;
      if (!ok || !ok2 || rx_str(id, base) != exp_str()) begin
        failures++;
        $display("FAIL rand_seq dut%0d word=%h got '%s' want '%s'",
                 id, w, rx_str(id, base), exp_str());
      end
      checks++;
      if (int'(rise_cnt[id]) - rbase != exp_q.size()) begin
        failures++;
        $display("FAIL rand_rises dut%0d got %0d want %0d",
                 id, int'(rise_cnt[id]) - rbase, exp_q.size());
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic16();
    test_directed();
    test_ext_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
